dcache: RTL and testbench

Direct-mapped, write-back data cache; the responder on the core's data-side request/flash interface. Serves word reads and byte-masked writes from an on-chip line array. On a miss it writes back a dirty victim line, then refills over a single-word backing-memory handshake. A flash request writes every dirty line back to memory and then signals completion, so instruction fetch can observe stored data.

---
 rtl/type_pkg.sv | 31 +++
 rtl/dcache_if.sv | 44 ++++
 rtl/dcache_line_array.sv | 58 +++++
 rtl/dcache.sv | 244 ++++++++++++++++++++++++
 tb/tb_dcache.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/type_pkg.sv
// Shared bus types for the core data side plus the dcache controller state encoding.
package type_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [BE_W-1:0]   byte_en_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_REFILL,
        ST_RESP,
        ST_FLUSH,
        ST_FDONE
    } dcache_state_t;

    // Replace the bytes of old_word selected by be with those of new_word.
    function automatic data_t merge_bytes(data_t old_word, data_t new_word, byte_en_t be);
        data_t res;
        res = old_word;
        for (int unsigned b = 0; b < BE_W; b++) begin
            if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dcache_if.sv
// Core-side request/flash bus and the single-word backing-memory bus of the data cache.
interface dcache_if;
    import type_pkg::*;

    logic     dcache_valid;
    addr_t    dcache_addr;
    data_t    dcache_wdata;
    byte_en_t dcache_byte_enable;
    logic     dcache_ready;
    data_t    dcache_rdata;
    logic     dcache_flash;
    logic     dcache_flash_done;

    modport master (
        output dcache_valid, dcache_addr, dcache_wdata, dcache_byte_enable, dcache_flash,
        input  dcache_ready, dcache_rdata, dcache_flash_done
    );

    modport slave (
        input  dcache_valid, dcache_addr, dcache_wdata, dcache_byte_enable, dcache_flash,
        output dcache_ready, dcache_rdata, dcache_flash_done
    );
endinterface

interface dcache_mem_if;
    import type_pkg::*;

    logic  mem_valid;
    logic  mem_we;
    addr_t mem_addr;
    data_t mem_wdata;
    logic  mem_ready;
    data_t mem_rdata;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/dcache_line_array.sv
// Flop-based line storage: combinational read by index, byte-masked word write, metadata write.
module dcache_line_array
    import type_pkg::*;
#(
    parameter int unsigned INDEX_BITS  = 6,
    parameter int unsigned OFFSET_BITS = 2,
    parameter int unsigned TAG_BITS    = 22
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [INDEX_BITS-1:0]                      idx,
    output logic                                       rd_valid_c,
    output logic                                       rd_dirty_c,
    output logic [TAG_BITS-1:0]                        rd_tag_c,
    output logic [(1<<OFFSET_BITS)-1:0][DATA_W-1:0]    rd_data_c,
    input  logic                                       wr_en,
    input  logic [OFFSET_BITS-1:0]                     wr_word,
    input  data_t                                      wr_data,
    input  byte_en_t                                   wr_be,
    input  logic                                       meta_en,
    input  logic                                       meta_valid,
    input  logic                                       meta_dirty,
    input  logic [TAG_BITS-1:0]                        meta_tag
);
    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned WORDS = 1 << OFFSET_BITS;

    logic [LINES-1:0]              valid_q;
    logic [LINES-1:0]              dirty_q;
    logic [TAG_BITS-1:0]           tag_q  [LINES];
    logic [WORDS-1:0][DATA_W-1:0]  data_q [LINES];

    assign rd_valid_c = valid_q[idx];
    assign rd_dirty_c = dirty_q[idx];
    assign rd_tag_c   = tag_q[idx];
    assign rd_data_c  = data_q[idx];

    // Only the status bits are cleared by reset; tags and data are don't-care until valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (meta_en) begin
            valid_q[idx] <= meta_valid;
            dirty_q[idx] <= meta_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (meta_en) tag_q[idx] <= meta_tag;
        if (wr_en) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (wr_be[b]) data_q[idx][wr_word][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back data cache: hit/miss FSM, victim write-back, refill and full flush.
module dcache
    import type_pkg::*;
#(
    parameter int unsigned INDEX_BITS  = 6,
    parameter int unsigned OFFSET_BITS = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    dcache_if.slave       core,
    dcache_mem_if.master  mem
);
    localparam int unsigned WORDS    = 1 << OFFSET_BITS;
    localparam int unsigned LINES    = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS = ADDR_W - INDEX_BITS - OFFSET_BITS - 2;

    dcache_state_t state_q, state_d;
    logic [OFFSET_BITS-1:0] word_q, word_d, next_word;
    logic [INDEX_BITS-1:0]  scan_q, scan_d;

    logic  ready_q, ready_d, flash_done_q, flash_done_d;
    data_t rdata_q, rdata_d;
    logic  mem_valid_q, mem_valid_d, mem_we_q, mem_we_d;
    addr_t mem_addr_q, mem_addr_d;
    data_t mem_wdata_q, mem_wdata_d;

    logic [OFFSET_BITS-1:0] req_off;
    logic [INDEX_BITS-1:0]  req_idx;
    logic [TAG_BITS-1:0]    req_tag;
    logic                   req_write;

    logic [INDEX_BITS-1:0]                   line_idx;
    logic                                    rd_valid, rd_dirty, hit;
    logic [TAG_BITS-1:0]                     rd_tag;
    logic [WORDS-1:0][DATA_W-1:0]            rd_data;
    logic                                    wr_en, meta_en, meta_valid, meta_dirty;
    logic [OFFSET_BITS-1:0]                  wr_word;
    data_t                                   wr_data, refill_word;
    byte_en_t                                wr_be;
    logic [TAG_BITS-1:0]                     meta_tag;
    logic                                    advance;

    assign req_off   = core.dcache_addr[2 +: OFFSET_BITS];
    assign req_idx   = core.dcache_addr[2+OFFSET_BITS +: INDEX_BITS];
    assign req_tag   = core.dcache_addr[ADDR_W-1 -: TAG_BITS];
    assign req_write = |core.dcache_byte_enable;
    assign hit       = rd_valid && (rd_tag == req_tag);
    assign next_word = word_q + OFFSET_BITS'(1);
    assign refill_word = merge_bytes(mem.mem_rdata, core.dcache_wdata, core.dcache_byte_enable);

    dcache_line_array #(
        .INDEX_BITS  (INDEX_BITS),
        .OFFSET_BITS (OFFSET_BITS),
        .TAG_BITS    (TAG_BITS)
    ) u_lines (
        .clk        (clk),
        .rst_n      (rst_n),
        .idx        (line_idx),
        .rd_valid_c (rd_valid),
        .rd_dirty_c (rd_dirty),
        .rd_tag_c   (rd_tag),
        .rd_data_c  (rd_data),
        .wr_en      (wr_en),
        .wr_word    (wr_word),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .meta_en    (meta_en),
        .meta_valid (meta_valid),
        .meta_dirty (meta_dirty),
        .meta_tag   (meta_tag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            word_q       <= '0;
            scan_q       <= '0;
            ready_q      <= 1'b0;
            flash_done_q <= 1'b0;
            rdata_q      <= '0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            scan_q       <= scan_d;
            ready_q      <= ready_d;
            flash_done_q <= flash_done_d;
            rdata_q      <= rdata_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        scan_d       = scan_q;
        ready_d      = 1'b0;
        flash_done_d = 1'b0;
        rdata_d      = rdata_q;
        mem_valid_d  = mem_valid_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        line_idx     = req_idx;
        wr_en        = 1'b0;
        wr_word      = req_off;
        wr_data      = core.dcache_wdata;
        wr_be        = core.dcache_byte_enable;
        meta_en      = 1'b0;
        meta_valid   = 1'b1;
        meta_dirty   = 1'b0;
        meta_tag     = req_tag;
        advance      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (core.dcache_valid) begin
                    word_d = '0;
                    if (hit) begin
                        wr_en      = req_write;
                        meta_en    = req_write;
                        meta_dirty = 1'b1;
                        rdata_d    = merge_bytes(rd_data[req_off], core.dcache_wdata,
                                                 core.dcache_byte_enable);
                        ready_d    = 1'b1;
                        state_d    = ST_RESP;
                    end else if (rd_valid && rd_dirty) begin
                        mem_valid_d = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {rd_tag, req_idx, OFFSET_BITS'(0), 2'b00};
                        mem_wdata_d = rd_data[0];
                        state_d     = ST_WB;
                    end else begin
                        mem_valid_d = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = {req_tag, req_idx, OFFSET_BITS'(0), 2'b00};
                        state_d     = ST_REFILL;
                    end
                end else if (core.dcache_flash) begin
                    scan_d  = '0;
                    word_d  = '0;
                    state_d = ST_FLUSH;
                end
            end

            ST_WB: begin
                if (mem.mem_ready) begin
                    mem_valid_d = 1'b1;
                    if (word_q == OFFSET_BITS'(WORDS - 1)) begin
                        word_d     = '0;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {req_tag, req_idx, OFFSET_BITS'(0), 2'b00};
                        state_d    = ST_REFILL;
                    end else begin
                        word_d      = next_word;
                        mem_addr_d  = {rd_tag, req_idx, next_word, 2'b00};
                        mem_wdata_d = rd_data[next_word];
                    end
                end
            end

            // The pending write is merged into its word as it arrives, so the
            // line is complete and correct on the final beat.
            ST_REFILL: begin
                if (mem.mem_ready) begin
                    wr_en   = 1'b1;
                    wr_word = word_q;
                    wr_be   = '1;
                    wr_data = mem.mem_rdata;
                    if (word_q == req_off) begin
                        wr_data = refill_word;
                        rdata_d = refill_word;
                    end
                    if (word_q == OFFSET_BITS'(WORDS - 1)) begin
                        meta_en     = 1'b1;
                        meta_dirty  = req_write;
                        mem_valid_d = 1'b0;
                        ready_d     = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        word_d     = next_word;
                        mem_addr_d = {req_tag, req_idx, next_word, 2'b00};
                    end
                end
            end

            ST_RESP: state_d = ST_IDLE;

            ST_FLUSH: begin
                line_idx = scan_q;
                meta_tag = rd_tag;
                if (mem_valid_q) begin
                    if (mem.mem_ready) begin
                        if (word_q == OFFSET_BITS'(WORDS - 1)) begin
                            mem_valid_d = 1'b0;
                            meta_en     = 1'b1;
                            advance     = 1'b1;
                        end else begin
                            word_d      = next_word;
                            mem_addr_d  = {rd_tag, scan_q, next_word, 2'b00};
                            mem_wdata_d = rd_data[next_word];
                        end
                    end
                end else if (rd_valid && rd_dirty) begin
                    word_d      = '0;
                    mem_valid_d = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {rd_tag, scan_q, OFFSET_BITS'(0), 2'b00};
                    mem_wdata_d = rd_data[0];
                end else begin
                    advance = 1'b1;
                end
            end

            ST_FDONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            if (scan_q == INDEX_BITS'(LINES - 1)) begin
                flash_done_d = 1'b1;
                state_d      = ST_FDONE;
            end else begin
                scan_d = scan_q + INDEX_BITS'(1);
            end
        end
    end

    assign core.dcache_ready      = ready_q;
    assign core.dcache_rdata      = rdata_q;
    assign core.dcache_flash_done = flash_done_q;
    assign mem.mem_valid          = mem_valid_q;
    assign mem.mem_we             = mem_we_q;
    assign mem.mem_addr           = mem_addr_q;
    assign mem.mem_wdata          = mem_wdata_q;

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed scenarios plus random traffic against a flat-memory model.
module tb_dcache;
    import type_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dcache_if     cif();
    dcache_mem_if mif();

    dcache #(.INDEX_BITS(6), .OFFSET_BITS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .core  (cif),
        .mem   (mif)
    );

    int total = 0;
    int bad   = 0;

    // Backing memory: unwritten words read back as their own address.
    bit [31:0] mem_data    [16384];
    bit        mem_written [16384];
    int        mem_wait = 0;
    int        wcnt = 0;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;
    xfer_t xlog[$];

    assign mif.mem_ready = mif.mem_valid && (wcnt == mem_wait);
    assign mif.mem_rdata = mem_written[mif.mem_addr[15:2]] ? mem_data[mif.mem_addr[15:2]]
                                                           : mif.mem_addr;

    always @(posedge clk) begin
        if (mif.mem_valid && mif.mem_ready) begin
            if (mif.mem_we) begin
                mem_data[mif.mem_addr[15:2]]    <= mif.mem_wdata;
                mem_written[mif.mem_addr[15:2]] <= 1'b1;
            end
            xlog.push_back('{mif.mem_we, mif.mem_addr, mif.mem_we ? mif.mem_wdata : mif.mem_rdata});
            wcnt <= 0;
        end else if (mif.mem_valid) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    // Core-visible memory: words written through the cache, else backing memory.
    data_t ref_mem [int unsigned];

    function automatic data_t backing(addr_t a);
        return mem_written[a[15:2]] ? mem_data[a[15:2]] : {a[31:2], 2'b00};
    endfunction

    function automatic data_t ref_rd(addr_t a);
        int unsigned k = int'(a >> 2);
        return ref_mem.exists(k) ? ref_mem[k] : backing(a);
    endfunction

    function automatic data_t ref_merge(data_t old_w, data_t new_w, byte_en_t be);
        data_t m;
        for (int i = 0; i < 4; i++)
            m[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return m;
    endfunction

    task automatic apply_reset();
        cif.dcache_valid = 1'b0;
        cif.dcache_flash = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_mem.delete();
    endtask

    task automatic core_access(input addr_t a, input data_t wd, input byte_en_t be,
                               output data_t rd, output int lat);
        @(posedge clk); #1;
        cif.dcache_valid       = 1'b1;
        cif.dcache_addr        = a;
        cif.dcache_wdata       = wd;
        cif.dcache_byte_enable = be;
        lat = 0;
        rd  = '0;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (cif.dcache_ready) begin
                rd = cif.dcache_rdata;
                break;
            end
            if (lat > 1000) begin
                total++; bad++;
                $display("FAIL access_timeout addr=%h no ready within %0d cycles", a, lat);
                break;
            end
        end
        cif.dcache_valid = 1'b0;
    endtask

    task automatic do_flash(output int cyc, output int done_cnt);
        @(posedge clk); #1;
        cif.dcache_flash = 1'b1;
        cyc = 0;
        done_cnt = 0;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            if (cif.dcache_flash_done) begin
                done_cnt++;
                cif.dcache_flash = 1'b0;
                break;
            end
            if (cyc > 5000) begin
                total++; bad++;
                $display("FAIL flash_timeout no flash_done within %0d cycles", cyc);
                cif.dcache_flash = 1'b0;
                break;
            end
        end
        repeat (3) begin
            @(posedge clk); #1;
            if (cif.dcache_flash_done) done_cnt++;
        end
    endtask

    task automatic test_reset();
        logic [7:0] outs;
        rst_n = 1'b0;
        #3;
        outs = {cif.dcache_ready, cif.dcache_flash_done, mif.mem_valid, mif.mem_we,
                |mif.mem_addr, |mif.mem_wdata, |cif.dcache_rdata, 1'b0};
        total++;
        if (outs !== 8'h00) begin
            bad++; $display("FAIL reset_outputs got=%b exp=00000000", outs);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (mif.mem_valid !== 1'b0) begin
            bad++; $display("FAIL reset_idle_mem_valid got=%b exp=0", mif.mem_valid);
        end
    endtask

    task automatic test_miss_hit();
        data_t rd; int lat; int s;
        s = xlog.size();
        core_access(32'h100, '0, 4'b0000, rd, lat);
        total++;
        if (xlog.size() - s != 4) begin
            bad++; $display("FAIL miss_xfer_count got=%0d exp=4", xlog.size() - s);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (xlog[s+i].we !== 1'b0 || xlog[s+i].addr !== 32'h100 + 32'(4*i)) begin
                bad++; $display("FAIL miss_read_%0d got we=%b addr=%h exp we=0 addr=%h",
                                i, xlog[s+i].we, xlog[s+i].addr, 32'h100 + 32'(4*i));
            end
        end
        total++;
        if (rd !== 32'h100) begin
            bad++; $display("FAIL miss_rdata got=%h exp=00000100", rd);
        end
        s = xlog.size();
        core_access(32'h104, '0, 4'b0000, rd, lat);
        total++;
        if (lat !== 1 || rd !== 32'h104 || xlog.size() != s) begin
            bad++; $display("FAIL hit_read got lat=%0d rdata=%h xfers=%0d exp lat=1 rdata=00000104 xfers=0",
                            lat, rd, xlog.size() - s);
        end
    endtask

    task automatic test_byte_write();
        data_t rd; int lat; int s;
        s = xlog.size();
        core_access(32'h100, 32'hAABBCCDD, 4'b0011, rd, lat);
        total++;
        if (lat !== 1 || xlog.size() != s) begin
            bad++; $display("FAIL byte_write_hit got lat=%0d xfers=%0d exp lat=1 xfers=0", lat, xlog.size() - s);
        end
        core_access(32'h100, '0, 4'b0000, rd, lat);
        total++;
        if (rd !== 32'h0000CCDD) begin
            bad++; $display("FAIL byte_write_readback got=%h exp=0000ccdd", rd);
        end
    endtask

    task automatic test_dirty_conflict();
        data_t rd; int lat; int s;
        logic [31:0] ea, ed;
        bit ew;
        s = xlog.size();
        core_access(32'h500, '0, 4'b0000, rd, lat);
        total++;
        if (xlog.size() - s != 8) begin
            bad++; $display("FAIL conflict_xfer_count got=%0d exp=8", xlog.size() - s);
        end
        for (int i = 0; i < 8; i++) begin
            ew = (i < 4);
            ea = ew ? 32'h100 + 32'(4*i) : 32'h500 + 32'(4*(i-4));
            ed = (i == 0) ? 32'h0000CCDD : ea;
            total++;
            if (xlog[s+i].we !== ew || xlog[s+i].addr !== ea || xlog[s+i].data !== ed) begin
                bad++; $display("FAIL conflict_xfer_%0d got we=%b addr=%h data=%h exp we=%b addr=%h data=%h",
                                i, xlog[s+i].we, xlog[s+i].addr, xlog[s+i].data, ew, ea, ed);
            end
        end
        total++;
        if (rd !== 32'h500) begin
            bad++; $display("FAIL conflict_rdata got=%h exp=00000500", rd);
        end
    endtask

    task automatic test_flash();
        data_t rd; int lat; int s; int cyc; int dn;
        logic [31:0] ea, ed;
        apply_reset();
        core_access(32'h30,  32'h11111111, 4'b1111, rd, lat);
        core_access(32'h288, 32'h22222222, 4'b1111, rd, lat);
        s = xlog.size();
        do_flash(cyc, dn);
        total++;
        if (xlog.size() - s != 8 || dn != 1) begin
            bad++; $display("FAIL flash_dirty got xfers=%0d done_pulses=%0d exp xfers=8 done_pulses=1",
                            xlog.size() - s, dn);
        end
        for (int i = 0; i < 8; i++) begin
            ea = (i < 4) ? 32'h30 + 32'(4*i) : 32'h280 + 32'(4*(i-4));
            ed = (ea == 32'h30) ? 32'h11111111 : (ea == 32'h288) ? 32'h22222222 : ea;
            total++;
            if (xlog[s+i].we !== 1'b1 || xlog[s+i].addr !== ea || xlog[s+i].data !== ed) begin
                bad++; $display("FAIL flash_write_%0d got we=%b addr=%h data=%h exp we=1 addr=%h data=%h",
                                i, xlog[s+i].we, xlog[s+i].addr, xlog[s+i].data, ea, ed);
            end
        end
        s = xlog.size();
        do_flash(cyc, dn);
        total++;
        if (xlog.size() != s || cyc != 65 || dn != 1) begin
            bad++; $display("FAIL flash_clean got xfers=%0d cycles=%0d done_pulses=%0d exp xfers=0 cycles=65 done_pulses=1",
                            xlog.size() - s, cyc, dn);
        end
    endtask

    task automatic test_simultaneous();
        data_t rd; int lat; int s; int cyc; int rdy_cyc; int done_cyc; int both;
        core_access(32'h3C0, 32'h5A5A5A5A, 4'b1111, rd, lat);
        s = xlog.size();
        @(posedge clk); #1;
        cif.dcache_valid = 1'b1; cif.dcache_addr = 32'h200;
        cif.dcache_byte_enable = 4'b0000; cif.dcache_flash = 1'b1;
        cyc = 0; rdy_cyc = -1; done_cyc = -1; both = 0;
        while (done_cyc < 0 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (cif.dcache_ready && cif.dcache_flash_done) both++;
            if (cif.dcache_ready) begin
                rd = cif.dcache_rdata; rdy_cyc = cyc; cif.dcache_valid = 1'b0;
            end
            if (cif.dcache_flash_done) begin
                done_cyc = cyc; cif.dcache_flash = 1'b0;
            end
        end
        cif.dcache_valid = 1'b0; cif.dcache_flash = 1'b0;
        total++;
        if (rdy_cyc < 0 || done_cyc <= rdy_cyc || both != 0 || rd !== 32'h200) begin
            bad++; $display("FAIL simul_order got ready_cyc=%0d done_cyc=%0d overlap=%0d rdata=%h exp ready before done rdata=00000200",
                            rdy_cyc, done_cyc, both, rd);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (xlog[s+i].we !== (i >= 4) ||
                xlog[s+i].addr !== ((i < 4) ? 32'h200 + 32'(4*i) : 32'h3C0 + 32'(4*(i-4)))) begin
                bad++; $display("FAIL simul_xfer_%0d got we=%b addr=%h", i, xlog[s+i].we, xlog[s+i].addr);
            end
        end
    endtask

    task automatic test_reset_mid_refill();
        data_t rd; int lat; int s; int n;
        logic [7:0] outs;
        mem_wait = 3;
        s = xlog.size();
        @(posedge clk); #1;
        cif.dcache_valid = 1'b1; cif.dcache_addr = 32'h600; cif.dcache_byte_enable = 4'b0000;
        n = 0;
        while (xlog.size() - s < 2 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (xlog.size() - s != 2 || mif.mem_valid !== 1'b1 || mif.mem_addr !== 32'h608) begin
            bad++; $display("FAIL rst_mid_progress got xfers=%0d mem_valid=%b mem_addr=%h exp xfers=2 mem_valid=1 mem_addr=00000608",
                            xlog.size() - s, mif.mem_valid, mif.mem_addr);
        end
        #1;
        rst_n = 1'b0;
        cif.dcache_valid = 1'b0;
        #1;
        outs = {cif.dcache_ready, cif.dcache_flash_done, mif.mem_valid, mif.mem_we,
                |mif.mem_addr, |mif.mem_wdata, |cif.dcache_rdata, 1'b0};
        total++;
        if (outs !== 8'h00) begin
            bad++; $display("FAIL rst_mid_outputs got=%b exp=00000000", outs);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_mem.delete();
        s = xlog.size();
        core_access(32'h600, '0, 4'b0000, rd, lat);
        total++;
        if (xlog.size() - s != 4 || xlog[s].addr !== 32'h600 || xlog[s+3].addr !== 32'h60C || rd !== 32'h600) begin
            bad++; $display("FAIL rst_mid_rerefill got xfers=%0d first=%h last=%h rdata=%h exp xfers=4 first=00000600 last=0000060c rdata=00000600",
                            xlog.size() - s, xlog[s].addr, xlog[s+3].addr, rd);
        end
        mem_wait = 0;
    endtask

    task automatic test_random();
        data_t rd, wd, exp; int lat; int cyc; int dn; int diffs;
        addr_t a; byte_en_t be;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            mem_wait = $urandom_range(0, 2);
            if ($urandom_range(0, 99) < 4 || n == 399) begin
                do_flash(cyc, dn);
                diffs = 0;
                foreach (ref_mem[k]) if (backing(addr_t'(k << 2)) !== ref_mem[k]) diffs++;
                total++;
                if (dn != 1 || diffs != 0) begin
                    bad++; $display("FAIL rand_flush op=%0d got done_pulses=%0d stale_words=%0d exp 1 and 0", n, dn, diffs);
                end
            end else begin
                a  = addr_t'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2));
                be = ($urandom_range(0, 1) == 0) ? 4'b0000 : byte_en_t'($urandom_range(1, 15));
                wd = $urandom;
                exp = ref_merge(ref_rd(a), wd, be);
                core_access(a, wd, be, rd, lat);
                if (be != 4'b0000) ref_mem[int'(a >> 2)] = exp;
                total++;
                if (rd !== exp) begin
                    bad++; $display("FAIL rand_access op=%0d addr=%h be=%b got=%h exp=%h", n, a, be, rd, exp);
                end
            end
        end
        mem_wait = 0;
    endtask

    initial begin
        cif.dcache_valid       = 1'b0;
        cif.dcache_addr        = '0;
        cif.dcache_wdata       = '0;
        cif.dcache_byte_enable = '0;
        cif.dcache_flash       = 1'b0;
        test_reset();
        test_miss_hit();
        test_byte_write();
        test_dirty_conflict();
        test_flash();
        test_simultaneous();
        test_reset_mid_refill();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
